clk_div_bank: RTL and testbench

Multi-channel, runtime-programmable clock divider. It generalises the fixed divide-by-8 toggle divider used in the CPU/PS2 clock tree. Each of NUM_CH channels produces a registered divided clock, with near-50% duty for any divisor, plus a one-cycle tick strobe. Divisors are reprogrammed at run time and take effect only at period boundaries, so outputs never glitch. Sits beside the CPU/PS2 logic and feeds slow-domain clocks and clock enables; downstream logic uses tick as an enable in preference to clk_out as a clock.

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_chan.sv | 81 ++++++++
 rtl/clk_div_bank.sv | 44 ++++
 tb/tb_clk_div_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-divider bank.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package clk_div_pkg;

    // Default divisor/counter width for the bank and its channels.
    localparam int DIV_W_DEF = 8;

    // Number of high cycles in one output period: ceil(d/2), so odd
    // divisors spend the extra cycle high (D=5 -> 3 high, 2 low).
    function automatic int unsigned half_high(input int unsigned d);
        return d - (d >> 1);
    endfunction

    // Per-channel state at the default width: active divisor, shadow
    // divisor, period counter and shadow-pending flag.
    typedef struct packed {
        logic [DIV_W_DEF-1:0] act_d;
        logic [DIV_W_DEF-1:0] sh_d;
        logic [DIV_W_DEF-1:0] cnt;
        logic                 pending;
    } chan_st_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow divisor, glitch-free period-boundary reload.
// Latency: clk_out/tick are flops reflecting the counter state of the same edge; config lands in shadow after 1 edge.
// Backpressure: none; writes always accepted, last write before a boundary wins.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_clr_i,
    input  logic             we_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             pending_o
);

    // Same layout as the package channel state, sized by this instance's width.
    typedef struct packed {
        logic [DIV_W-1:0] act_d;
        logic [DIV_W-1:0] sh_d;
        logic [DIV_W-1:0] cnt;
        logic             pending;
    } st_t;

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
    // Reset parks the counter on the last count so the first edge is a boundary.
    localparam logic [DIV_W-1:0] RST_CNT = (DEFAULT_DIV == 0) ? '0 : DIV_W'(DEFAULT_DIV - 1);

    st_t  st_q, st_d;
    logic clk_out_q, clk_out_d;
    logic tick_q, tick_d;
    logic bnd;

    // Next state: reload at boundaries, count otherwise, capture writes into the shadow.
    always_comb begin
        st_d      = st_q;
        // A stopped channel (act_d==0) sits on a permanent boundary so a
        // non-zero shadow restarts it on the very next edge.
        bnd       = sync_clr_i
                  || (st_q.act_d == '0)
                  || (st_q.cnt == st_q.act_d - DIV_W'(1));
        if (bnd) begin
            st_d.act_d   = st_q.sh_d;
            st_d.cnt     = '0;
            st_d.pending = 1'b0;
        end else begin
            st_d.cnt     = st_q.cnt + DIV_W'(1);
        end
        // A write coinciding with a boundary goes to the shadow after the
        // boundary consumed the old shadow, and keeps pending set.
        if (we_i) begin
            st_d.sh_d    = div_i;
            st_d.pending = 1'b1;
        end
        // Outputs are decoded from the next state so they are pure flops.
        tick_d    = bnd && (st_d.act_d != '0);
        clk_out_d = (st_d.act_d != '0)
                  && (32'(st_d.cnt) < half_high(32'(st_d.act_d)));
    end

    // State and output registers with asynchronous reset to the boundary state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= '{act_d: RST_DIV, sh_d: RST_DIV, cnt: RST_CNT, pending: 1'b0};
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign pending_o = st_q.pending;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers with per-channel tick strobes.
// Latency: outputs are channel flops; divisor writes reach the shadow in 1 cycle, the output at the next boundary.
// Backpressure: none; out-of-range channel writes are silently dropped.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  DIV_W       = DIV_W_DEF,
    parameter int  DEFAULT_DIV = 8,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    logic [NUM_CH-1:0] ch_we;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Only channel indices that exist can match, so codes >= NUM_CH hit nothing.
        assign ch_we[g] = cfg_we && (cfg_ch == CH_W'(g));

        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .sync_clr_i (sync_clr),
            .we_i       (ch_we[g]),
            .div_i      (cfg_div),
            .clk_out_o  (clk_out[g]),
            .tick_o     (tick[g]),
            .pending_o  (cfg_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: 5 channels, 8-bit divisors, reset divisor 8.
// Latency: edges are counted from reset release (edge 1 = first rising edge after release).
// Backpressure: n/a; outputs sampled on the falling edge, inputs driven there too.
module tb_clk_div_bank;

    logic       clk;
    logic       reset;
    logic       sync_clr;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [4:0] clk_out;
    logic [4:0] tick;
    logic [4:0] cfg_pending;

    int cyc;
    int n_chk;
    int n_fail;

    clk_div_bank #(
        .NUM_CH      (5),
        .DIV_W       (8),
        .DEFAULT_DIV (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sync_clr    (sync_clr),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic wr(input int ch, input int d);
        cfg_we  = 1'b1;
        cfg_ch  = 3'(ch);
        cfg_div = 8'(d);
        step();
        cfg_we  = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_clk_out", clk_out, 5'h00);
        chk("rst_tick", tick, 5'h00);
        chk("rst_pending", cfg_pending, 5'h00);
        reset = 1'b0;

        // Default divide-by-8: ticks at 1, 9; high 1-4, low 5-8
        for (int c = 1; c <= 16; c++) begin
            step();
            chk("def_tick", tick, (((cyc - 1) % 8) == 0) ? 5'h1F : 5'h00);
            chk("def_clk", clk_out, (((cyc - 1) % 8) < 4) ? 5'h1F : 5'h00);
        end

        // Mid-period write ch2 D=5: pending until edge 25, then 3 high / 2 low
        run_to(19);
        wr(2, 5);
        chk("d5_pend_set", cfg_pending, 5'b00100);
        run_to(24);
        chk("d5_pend_hold", cfg_pending, 5'b00100);
        step();
        chk("d5_pend_clr", cfg_pending, 5'b00000);
        chk("d5_tick_bnd", tick, 5'h1F);
        chk("d5_clk_bnd", clk_out, 5'h1F);
        for (int c = 26; c <= 34; c++) begin
            step();
            chk("d5_ch2_tick", tick[2], ((cyc - 25) % 5) == 0);
            chk("d5_ch2_clk", clk_out[2], ((cyc - 25) % 5) < 3);
            chk("d5_oth_clk", clk_out & 5'b11011, (((cyc - 25) % 8) < 4) ? 5'b11011 : 5'b00000);
        end

        // Write D=3 on ch2's boundary edge 35: one more 5-period, then period 3
        wr(2, 3);
        chk("b3_pend_set", cfg_pending[2], 1'b1);
        chk("b3_tick35", tick[2], 1'b1);
        run_to(39);
        chk("b3_pend_hold", cfg_pending[2], 1'b1);
        chk("b3_tick39", tick[2], 1'b0);
        chk("b3_clk39", clk_out[2], 1'b0);
        step();
        chk("b3_pend_clr", cfg_pending[2], 1'b0);
        chk("b3_tick40", tick[2], 1'b1);
        for (int c = 41; c <= 46; c++) begin
            step();
            chk("b3_ch2_tick", tick[2], ((cyc - 40) % 3) == 0);
            chk("b3_ch2_clk", clk_out[2], ((cyc - 40) % 3) < 2);
        end

        // D=0 stops ch2 at edge 49; D=6 written at 53 restarts it at 54
        wr(2, 0);
        chk("d0_pend", cfg_pending[2], 1'b1);
        chk("d0_clk47", clk_out[2], 1'b1);
        step();
        chk("d0_clk48", clk_out[2], 1'b0);
        for (int c = 49; c <= 52; c++) begin
            step();
            chk("d0_stop_tick", tick[2], 1'b0);
            chk("d0_stop_clk", clk_out[2], 1'b0);
        end
        chk("d0_pend_clr", cfg_pending[2], 1'b0);
        wr(2, 6);
        chk("d6_pend", cfg_pending[2], 1'b1);
        chk("d6_tick53", tick[2], 1'b0);
        chk("d6_clk53", clk_out[2], 1'b0);
        for (int c = 54; c <= 60; c++) begin
            step();
            chk("d6_ch2_tick", tick[2], ((cyc - 54) % 6) == 0);
            chk("d6_ch2_clk", clk_out[2], ((cyc - 54) % 6) < 3);
        end

        // ch0=4, ch1=6 applied at edge 65; sync_clr at edge 71 realigns everything
        wr(0, 4);
        wr(1, 6);
        chk("sc_pend", cfg_pending, 5'b00011);
        run_to(65);
        chk("sc_pend_clr", cfg_pending, 5'b00000);
        chk("sc_tick65", tick, 5'b11011);
        run_to(69);
        chk("sc_tick69", tick, 5'b00001);
        step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("sc_tick71", tick, 5'h1F);
        chk("sc_clk71", clk_out, 5'h1F);
        for (int c = 72; c <= 83; c++) begin
            step();
            chk("sc_ch0_tick", tick[0], ((cyc - 71) % 4) == 0);
            chk("sc_ch1_tick", tick[1], ((cyc - 71) % 6) == 0);
            chk("sc_ch0_clk", clk_out[0], ((cyc - 71) % 4) < 2);
            chk("sc_ch1_clk", clk_out[1], ((cyc - 71) % 6) < 3);
        end
        chk("sc_tick83", tick[1:0], 2'b11);

        // ch3 D=1 plus out-of-range writes to channels 5 and 7
        wr(3, 1);
        chk("d1_pend", cfg_pending, 5'b01000);
        wr(5, 1);
        chk("oor5_pend", cfg_pending, 5'b01000);
        wr(7, 1);
        chk("oor7_pend", cfg_pending, 5'b01000);
        step();
        chk("d1_pend_clr", cfg_pending, 5'b00000);
        chk("d1_tick87", tick[3], 1'b1);
        for (int c = 88; c <= 95; c++) begin
            step();
            chk("d1_tick", tick[3], 1'b1);
            chk("d1_clk", clk_out[3], 1'b1);
            chk("oor_ch4_tick", tick[4], ((cyc - 71) % 8) == 0);
            chk("oor_ch4_clk", clk_out[4], ((cyc - 71) % 8) < 4);
            chk("oor_ch0_tick", tick[0], ((cyc - 71) % 4) == 0);
        end

        // Mid-period async reset discards all state including a pending write
        wr(1, 2);
        chk("mr_pend_pre", cfg_pending, 5'b00010);
        #2 reset = 1'b1;
        #1;
        chk("mr_clk_out", clk_out, 5'h00);
        chk("mr_tick", tick, 5'h00);
        chk("mr_pending", cfg_pending, 5'h00);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        step();
        chk("mr_tick1", tick, 5'h1F);
        chk("mr_clk1", clk_out, 5'h1F);
        run_to(3);
        chk("mr_tick3", tick, 5'h00);
        run_to(5);
        chk("mr_clk5", clk_out, 5'h00);
        run_to(9);
        chk("mr_tick9", tick, 5'h1F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
